// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request-capture stage: channel count,
// handshake FSM encoding and holdoff counter width.
package irq_pkg;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } irq_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// One request channel: SYNC_STAGES-deep synchroniser followed by an edge or
// level event detector.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_async,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d1;
  logic [SYNC_STAGES:0]   arm_q;
  logic                   sync_v;

  assign sync_v = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      sync_d1 <= 1'b0;
      arm_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], irq_async};
      sync_d1 <= sync_v;
      arm_q   <= {arm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edges are only trusted once both sync_v and sync_d1 hold post-reset samples,
  // so a line held high through reset does not look like a fresh rising edge.
  assign evt = (EDGE_MODE != 0) ? (sync_v & ~sync_d1 & arm_q[SYNC_STAGES]) : sync_v;

endmodule

// File: rtl/irq_pending_latch4.sv
// Request-capture stage for the 4:2 priority encoder: synchronised events set
// sticky pending bits, which are presented masked under a valid/ack handshake.
import irq_pkg::*;

module irq_pending_latch4 #(
  parameter int SYNC_STAGES    = 2,
  parameter int EDGE_MODE      = 1,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] irq_in,
  input  logic [3:0] mask,
  input  logic       ack,
  input  logic [1:0] ack_idx,
  input  logic       clr_all,
  output logic [3:0] pend,
  output logic       enc_en,
  output logic       irq_valid,
  output logic [3:0] ovf
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES);

  logic [NUM_CH-1:0] evt;
  logic [NUM_CH-1:0] clr_vec;
  logic [NUM_CH-1:0] pend_reg;
  logic [NUM_CH-1:0] ovf_reg;
  logic [NUM_CH-1:0] masked;
  irq_state_e        state;
  logic [CNT_W-1:0]  hold_cnt;
  logic              valid_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sync_edge_det #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_MODE  (EDGE_MODE)
    ) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .irq_async(irq_in[i]),
      .evt      (evt[i])
    );
  end

  // Handshake: irq_valid is high exactly in REQ; the consumer samples pend only
  // then, and an ack is honoured only in REQ, clearing bit ack_idx that cycle.
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      clr_vec[i] = ack && (state == REQ) && (ack_idx == 2'(i));
    end
  end

  assign masked = pend_reg & ~mask;

  // A new event beats a same-cycle clear so it is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_all) begin
      pend_reg <= '0;
      ovf_reg  <= '0;
    end else begin
      pend_reg <= (pend_reg & ~clr_vec) | evt;
      ovf_reg  <= ovf_reg | (evt & pend_reg & ~clr_vec);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|masked) begin
            state   <= REQ;
            valid_q <= 1'b1;
          end
        end
        REQ: begin
          if (ack) begin
            valid_q <= 1'b0;
            if (HOLD_LOAD == '0) begin
              state <= IDLE;
            end else begin
              state    <= HOLD;
              hold_cnt <= HOLD_LOAD;
            end
          end else if (clr_all || !(|masked)) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt <= CNT_W'(1)) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pend      = masked;
  assign irq_valid = valid_q;
  assign enc_en    = valid_q;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_irq_pending_latch4.sv
// Bench for irq_pending_latch4: directed scenarios with literal expectations,
// then randomized traffic, all checked each cycle against a behavioural model.
module tb_irq_pending_latch4;

  localparam int S    = 2;
  localparam int EDGE = 1;
  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] irq_in = 4'h0;
  logic [3:0] mask = 4'h0;
  logic       ack = 1'b0;
  logic [1:0] ack_idx = 2'd0;
  logic       clr_all = 1'b0;
  logic [3:0] pend;
  logic       enc_en;
  logic       irq_valid;
  logic [3:0] ovf;

  int checks = 0;
  int failures = 0;

  irq_pending_latch4 #(
    .SYNC_STAGES   (S),
    .EDGE_MODE     (EDGE),
    .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_in   (irq_in),
    .mask     (mask),
    .ack      (ack),
    .ack_idx  (ack_idx),
    .clr_all  (clr_all),
    .pend     (pend),
    .enc_en   (enc_en),
    .irq_valid(irq_valid),
    .ovf      (ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: raw input history, pending/overflow sets, presentation phase
  bit [3:0] smp[$];
  int       smp_cnt;
  bit [3:0] m_pend, m_ovf;
  bit       m_present;
  int       m_hold;
  logic [8:0] exp_q[$];

  task automatic model_step();
    bit [3:0] sync_v, prev_v, ev, old_pend, vis;
    bit       was_present, c;
    if (!rst_n) begin
      m_pend = '0; m_ovf = '0; m_present = 1'b0; m_hold = 0;
      smp.delete();
      for (int i = 0; i <= S; i++) smp.push_back(4'h0);
      smp_cnt = 0;
    end else begin
      sync_v = smp[S-1];
      prev_v = smp[S];
      if (EDGE != 0) ev = (smp_cnt >= S + 1) ? (sync_v & ~prev_v) : 4'h0;
      else ev = sync_v;
      old_pend = m_pend;
      vis = old_pend & ~mask;
      was_present = m_present;
      if (m_present) begin
        if (ack) begin
          m_present = 1'b0;
          m_hold = HOLD;
        end else if (clr_all || vis == 0) begin
          m_present = 1'b0;
        end
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (vis != 0) begin
        m_present = 1'b1;
      end
      if (clr_all) begin
        m_pend = '0;
        m_ovf = '0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          c = was_present && ack && (ack_idx == 2'(i));
          if (ev[i]) begin
            if (old_pend[i] && !c) m_ovf[i] = 1'b1;
            m_pend[i] = 1'b1;
          end else if (c) begin
            m_pend[i] = 1'b0;
          end
        end
      end
      smp.push_front(irq_in);
      void'(smp.pop_back());
      smp_cnt++;
    end
    exp_q.push_back({m_pend & ~mask, m_ovf, m_present});
  endtask

  // scoreboard: model at each edge, compare just after it
  always @(posedge clk) begin
    logic [8:0] e;
    model_step();
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cyc_pend", pend, e[8:5]);
      chk("cyc_ovf", ovf, e[4:1]);
      chk("cyc_irq_valid", 4'(irq_valid), 4'(e[0]));
      chk("cyc_enc_en", 4'(enc_en), 4'(e[0]));
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] v);
    irq_in = v;
    cyc(1);
    irq_in = 4'h0;
  endtask

  task automatic do_ack(input logic [1:0] idx);
    ack = 1'b1;
    ack_idx = idx;
    cyc(1);
    ack = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (irq_valid !== 1'b1 && n < budget) begin
      cyc(1);
      n++;
    end
    chk("wait_valid", 4'(irq_valid), 4'h1);
  endtask

  initial begin
    // reset with all lines high
    rst_n = 1'b0;
    irq_in = 4'hF;
    cyc(3);
    chk("rst_pend", pend, 4'h0);
    chk("rst_ovf", ovf, 4'h0);
    chk("rst_valid", 4'(irq_valid), 4'h0);
    chk("rst_enc_en", 4'(enc_en), 4'h0);
    rst_n = 1'b1;
    cyc(6);
    chk("held_high_pend", pend, 4'h0);
    chk("held_high_valid", 4'(irq_valid), 4'h0);
    irq_in = 4'h0;
    cyc(4);

    // single event on ch2
    pulse(4'b0100);
    cyc(1);
    chk("single_pend_e2", pend, 4'h0);
    cyc(1);
    chk("single_pend_e3", pend, 4'b0100);
    chk("single_valid_e3", 4'(irq_valid), 4'h0);
    cyc(1);
    chk("single_valid_e4", 4'(irq_valid), 4'h1);
    do_ack(2'd2);
    chk("single_ack_pend", pend, 4'h0);
    chk("single_hold1", 4'(irq_valid), 4'h0);
    cyc(1);
    chk("single_hold2", 4'(irq_valid), 4'h0);
    cyc(4);

    // ch0 and ch3 together
    pulse(4'b1001);
    cyc(2);
    chk("prio_pend", pend, 4'b1001);
    cyc(1);
    chk("prio_valid", 4'(irq_valid), 4'h1);
    do_ack(2'd3);
    chk("prio_ack3_pend", pend, 4'b0001);
    cyc(2);
    chk("prio_holdoff_valid", 4'(irq_valid), 4'h0);
    wait_valid(6);
    do_ack(2'd0);
    chk("prio_ack0_pend", pend, 4'h0);
    cyc(5);

    // set/clear collision on ch1
    pulse(4'b0010);
    wait_valid(8);
    irq_in = 4'b0010;
    cyc(1);
    irq_in = 4'h0;
    cyc(1);
    do_ack(2'd1);
    chk("coll_pend", pend, 4'b0010);
    chk("coll_ovf", ovf, 4'h0);
    chk("coll_valid", 4'(irq_valid), 4'h0);
    wait_valid(8);
    do_ack(2'd1);
    cyc(5);

    // overflow on ch3, then clr_all in REQ
    pulse(4'b1000);
    cyc(1);
    pulse(4'b1000);
    cyc(3);
    chk("ovf_ovf", ovf, 4'b1000);
    chk("ovf_pend", pend, 4'b1000);
    chk("ovf_valid", 4'(irq_valid), 4'h1);
    clr_all = 1'b1;
    cyc(1);
    clr_all = 1'b0;
    chk("clr_pend", pend, 4'h0);
    chk("clr_ovf", ovf, 4'h0);
    chk("clr_valid", 4'(irq_valid), 4'h0);
    cyc(3);

    // masking, unmask, ack ignored in HOLD
    mask = 4'b0100;
    pulse(4'b0100);
    cyc(4);
    chk("mask_pend", pend, 4'h0);
    chk("mask_valid", 4'(irq_valid), 4'h0);
    mask = 4'h0;
    #1;
    chk("unmask_pend", pend, 4'b0100);
    chk("unmask_valid_now", 4'(irq_valid), 4'h0);
    cyc(1);
    chk("unmask_valid", 4'(irq_valid), 4'h1);
    pulse(4'b0001);
    cyc(2);
    chk("mask_two_pend", pend, 4'b0101);
    do_ack(2'd2);
    chk("hold_pend", pend, 4'b0001);
    do_ack(2'd0);
    chk("hold_ack_ignored", pend, 4'b0001);
    wait_valid(8);
    do_ack(2'd0);
    chk("final_ack_pend", pend, 4'h0);
    cyc(5);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) irq_in[i] = ~irq_in[i];
      if ($urandom_range(0, 39) == 0)
        mask = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      ack_idx = 2'($urandom_range(0, 3));
      if (irq_valid === 1'b1 && $urandom_range(0, 2) == 0) begin
        ack = 1'b1;
        if ($urandom_range(0, 3) != 0)
          for (int i = 0; i < 4; i++) if (pend[i]) ack_idx = 2'(i);
      end else begin
        ack = ($urandom_range(0, 19) == 0);
      end
      clr_all = ($urandom_range(0, 59) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      cyc(1);
    end
    ack = 1'b0;
    clr_all = 1'b0;
    rst_n = 1'b1;
    irq_in = 4'h0;
    cyc(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
